load_store_unit: RTL and testbench

//  Sequences RV32I loads/stores from the execute stage into the byte-addressed data RAM.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_formatter.sv | 24 ++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// RAM byte-mode encodings and access decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] MODE_B = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_W = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

  function automatic logic [1:0] mode_of(input logic [2:0] size);
    logic [1:0] mode;
    case (size)
      3'd1:    mode = MODE_B;
      3'd2:    mode = MODE_H;
      default: mode = MODE_W;
    endcase
    return mode;
  endfunction

  // Last byte computed in 33 bits so an access near 2^32-1 cannot wrap into range.
  function automatic logic range_fault(input logic [31:0] addr, input logic [2:0] size,
                                       input logic [31:0] lo, input logic [31:0] hi);
    logic [32:0] last;
    last = {1'b0, addr} + {30'd0, size} - 33'd1;
    return (addr < lo) || (last > {1'b0, hi});
  endfunction

endpackage

// File: rtl/lsu_load_formatter.sv
// Combinational load-data extension: sign- or zero-extends the RAM lanes
// according to the load funct3.
module lsu_load_formatter
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Select extension by load width and signedness.
  always_comb begin
    data = 32'd0;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    data = raw;
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a byte-addressed data RAM:
// one access in flight, fault decode at acceptance, registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = 32'd0,
  parameter logic [31:0] STOP_ADDRESS  = 32'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_wr_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_wr_mode,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  output logic [1:0]  mem_rd_mode,
  input  logic [31:0] mem_rd_data
);

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        fault_s;
  logic        illegal_s;
  logic        misalign_s;
  logic [2:0]  size_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  mode_r;
  logic [31:0] fmt_data_s;
  logic        access_s;

  lsu_load_formatter u_fmt (
    .funct3 (funct3_r),
    .raw    (mem_rd_data),
    .data   (fmt_data_s)
  );

  // Fault decode of the presented request.
  always_comb begin
    size_s = size_of(req_funct3);
    if (req_we) begin
      illegal_s = (req_funct3 >= 3'd3);
    end else begin
      illegal_s = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    end
    misalign_s = ((size_s == 3'd2) && req_addr[0]) ||
                 ((size_s == 3'd4) && (req_addr[1:0] != 2'b00));
    fault_s = illegal_s || misalign_s ||
              range_fault(req_addr, size_s, START_ADDRESS, STOP_ADDRESS);
  end

  // Next-state logic; faulted requests bypass the RAM cycle.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s     = 1'b1;
          next_state_s = fault_s ? RESP : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS:  next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      funct3_r   <= 3'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      mode_r     <= MODE_B;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
        mode_r   <= mode_of(size_s);
      end
      resp_valid <= (next_state_s == RESP);
      resp_error <= accept_s && fault_s;
      resp_rdata <= ((state_r == ACCESS) && !we_r) ? fmt_data_s : 32'd0;
    end
  end

  assign req_ready = (state_r == IDLE);
  assign access_s  = (state_r == ACCESS);

  // RAM port drive; everything is zero outside the single ACCESS cycle.
  always_comb begin
    mem_wr_en   = access_s && we_r && !rst;
    mem_wr_addr = (access_s && we_r) ? addr_r  : 32'd0;
    mem_wr_data = (access_s && we_r) ? wdata_r : 32'd0;
    mem_wr_mode = (access_s && we_r) ? mode_r  : MODE_B;
    mem_rd_en   = access_s && !we_r;
    mem_rd_addr = (access_s && !we_r) ? addr_r : 32'd0;
    mem_rd_mode = (access_s && !we_r) ? mode_r : MODE_B;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte RAM stand-in, high-level
// access model with an expectation queue, per-cycle compare process.
module tb_load_store_unit;

  localparam longint START = 0;
  localparam longint STOP  = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_error, mem_wr_en, mem_rd_en;
  logic [31:0] resp_rdata, mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;
  logic [1:0]  mem_wr_mode, mem_rd_mode;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_wr_mode(mem_wr_mode), .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_mode(mem_rd_mode), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;
  int busy_from = 0;
  int free_at = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM stand-in: writes commit on the clock edge, reads are combinational.
  logic [7:0] ram [0:1023];
  logic [7:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_wr_addr[9:0]] <= mem_wr_data[7:0];
      if (mem_wr_mode != 2'b00) ram[mem_wr_addr[9:0] + 10'd1] <= mem_wr_data[15:8];
      if (mem_wr_mode == 2'b11) begin
        ram[mem_wr_addr[9:0] + 10'd2] <= mem_wr_data[23:16];
        ram[mem_wr_addr[9:0] + 10'd3] <= mem_wr_data[31:24];
      end
    end
  end

  always_comb begin
    mem_rd_data = 32'd0;
    mem_rd_data[7:0] = ram[mem_rd_addr[9:0]];
    if (mem_rd_mode != 2'b00) mem_rd_data[15:8] = ram[mem_rd_addr[9:0] + 10'd1];
    if (mem_rd_mode == 2'b11) begin
      mem_rd_data[23:16] = ram[mem_rd_addr[9:0] + 10'd2];
      mem_rd_data[31:24] = ram[mem_rd_addr[9:0] + 10'd3];
    end
  end

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Architectural model of one access, straight from the RV32I rules.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                       output logic [1:0] mode);
    int size;
    longint a;
    longint unsigned raw;
    longint val;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mode = (size == 1) ? 2'b00 : (size == 2) ? 2'b01 : 2'b11;
    a = longint'({32'd0, addr});
    err = (we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6)) ||
          (a % size != 0) || (a < START) || (a + size - 1 > STOP);
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end else begin
        raw = 0;
        for (int i = 0; i < size; i++) raw = raw + (longint'(ref_mem[int'(a) + i]) << (8 * i));
        val = longint'(raw);
        if (f3 == 3'd0 && val >= 128) val = val - 256;
        if (f3 == 3'd1 && val >= 32768) val = val - 65536;
        rdata = val[31:0];
      end
    end
  endtask

  // Drive one request (called just after a rising edge); returns just after acceptance.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit abort, input bit hold,
                       input logic [31:0] pin_rdata, input bit pin_err);
    int n;
    int e0;
    bit err;
    logic [31:0] rdata;
    logic [1:0] mode;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    if (abort) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      busy_from = 0; free_at = 0;
      return;
    end
    model(we, f3, addr, wdata, err, rdata, mode);
    check("model_err", {31'd0, err}, {31'd0, pin_err});
    check("model_rdata", rdata, pin_rdata);
    e.cyc = e0 + (err ? 0 : 1); e.err = err; e.rdata = rdata; e.we = we;
    e.addr = addr; e.wdata = wdata; e.mode = mode;
    q.push_back(e);
    busy_from = e0;
    free_at = e0 + (err ? 1 : 2);
    @(posedge clk); #1;
    req_valid = hold;
  endtask

  // Per-cycle comparison against the queued expectations.
  always @(negedge clk) begin
    bit in_access;
    if (started) begin
      if (rst) begin
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      end else begin
        check("req_ready", {31'd0, req_ready}, {31'd0, !(cyc >= busy_from && cyc < free_at)});
        in_access = (q.size() > 0) && !q[0].err && (cyc == q[0].cyc - 1);
        check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, in_access && q[0].we});
        check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, in_access && !q[0].we});
        if (in_access && q[0].we) begin
          check("wr_addr", mem_wr_addr, q[0].addr);
          check("wr_data", mem_wr_data, q[0].wdata);
          check("wr_mode", {30'd0, mem_wr_mode}, {30'd0, q[0].mode});
        end else if (in_access) begin
          check("rd_addr", mem_rd_addr, q[0].addr);
          check("rd_mode", {30'd0, mem_rd_mode}, {30'd0, q[0].mode});
        end
        if (q.size() > 0 && cyc == q[0].cyc) begin
          check("resp_valid", {31'd0, resp_valid}, 32'd1);
          check("resp_error", {31'd0, resp_error}, {31'd0, q[0].err});
          check("resp_rdata", resp_rdata, q[0].rdata);
          void'(q.pop_front());
        end else begin
          check("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_error", {31'd0, resp_error}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    check("reset_mem_addr", mem_wr_addr | mem_rd_addr | mem_wr_data, 32'd0);
    check("reset_mem_mode", {28'd0, mem_wr_mode, mem_rd_mode}, 32'd0);
    started = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // word store/load
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    // byte store, signed and unsigned byte loads
    issue(1'b1, 3'd0, 32'h21, 32'h00000080, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd0, 32'h21, 32'h0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 3'd4, 32'h21, 32'h0, 1'b0, 1'b0, 32'h00000080, 1'b0);
    // half store, signed and unsigned half loads
    issue(1'b1, 3'd1, 32'h30, 32'h12348001, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd1, 32'h30, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 1'b0);
    issue(1'b0, 3'd5, 32'h30, 32'h0, 1'b0, 1'b0, 32'h00008001, 1'b0);
    // misaligned and out-of-range faults
    issue(1'b0, 3'd1, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 3'd2, 32'h22, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'd1022, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'd1024, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'd5, 32'd1023, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    // illegal funct3
    issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 3'd4, 32'h10, 32'h77, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'd7, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    // upper-boundary accesses that stay in range
    issue(1'b1, 3'd2, 32'd1020, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'd1020, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 3'd0, 32'd1023, 32'h0, 1'b0, 1'b0, 32'hFFFFFFCA, 1'b0);
    issue(1'b0, 3'd1, 32'd1022, 32'h0, 1'b0, 1'b0, 32'hFFFFCAFE, 1'b0);
    // back-to-back loads with req_valid held high
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'h23228020, 1'b0);
    issue(1'b0, 3'd2, 32'h14, 32'h0, 1'b0, 1'b0, 32'h17161514, 1'b0);
    // reset during the ACCESS of a store drops it
    issue(1'b1, 3'd2, 32'h40, 32'h11223344, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0, 32'h43424140, 1'b0);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("drain_pending", q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
